// File: rtl/haar_scan_engine.sv
// rtl/haar_scan_engine.sv - Haar dark-over-bright band detector scanning an integral image tile
//
// Scans every window position and scale of a two-band Haar filter over a D x D tile whose
// integral image lives in an external memory with a 1-cycle read latency.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a scan (sampled only when idle)
//   tile_dim, base_w      : tile side D and scale-0 filter width, latched at start
//   t_dark, t_bright      : top-band / bottom-band mean thresholds, latched at start
//   mem_rd_en, mem_addr   : integral-memory read strobe and address y*(D+1)+x
//   mem_rd_data           : read data, valid the cycle after mem_rd_en
//   hit_valid, hit_ready  : hit-record handshake
//   hit_x, hit_y, hit_scale : hit window top-left and scale index
//   busy, done            : scan in progress, one-cycle end-of-scan pulse
//   hit_count, cfg_err    : saturating hit counter, bad-config flag (H == 0)
module haar_scan_engine #(
   parameter int PIX_W      = 32,
   parameter int ADDR_W     = 17,
   parameter int DIM_W      = 10,
   parameter int MAX_SCALES = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIM_W-1:0]  tile_dim,
   input  logic [DIM_W-1:0]  base_w,
   input  logic [7:0]        t_dark,
   input  logic [7:0]        t_bright,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic              hit_valid,
   input  logic              hit_ready,
   output logic [DIM_W-1:0]  hit_x,
   output logic [DIM_W-1:0]  hit_y,
   output logic [2:0]        hit_scale,
   output logic              busy,
   output logic              done,
   output logic [15:0]       hit_count,
   output logic              cfg_err
);
   localparam int WW = DIM_W + 1;   // filter width may grow past D just before the scan ends
   localparam int CW = DIM_W + 2;   // headroom for x+W, y+2H and limit comparisons
   localparam int EW = PIX_W + 8;
   localparam logic [3:0] MAX_S = 4'(MAX_SCALES);

   typedef enum logic [2:0] {IDLE, SETUP, FETCH, EVAL, EMIT, DONE} state_t;
   state_t state;

   logic [DIM_W-1:0] d_q, w0_q, x_q, y_q;
   logic [7:0]       td_q, tb_q;
   logic [WW-1:0]    w_q, h_q;
   logic [3:0]       s_q;
   logic [2:0]       fc;
   logic [PIX_W-1:0] rd [0:5];

   function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [CW-1:0] pitch);
      return ADDR_W'(row) * ADDR_W'(pitch) + ADDR_W'(col);
   endfunction

   logic [CW-1:0] pitch, f_row, f_col;
   logic [2:0]    nj;
   logic [WW-1:0] setup_h;

   // Corner for the next FETCH read: pairs (x, x+W) on rows y, y+H, y+2H.
   always_comb begin
      pitch   = CW'(d_q) + CW'(1);
      setup_h = WW'(w0_q) / WW'(6);
      nj      = fc + 3'd1;
      f_row   = CW'(y_q);
      if (nj[2:1] == 2'd1)
         f_row = CW'(y_q) + CW'(h_q);
      else if (nj[2:1] == 2'd2)
         f_row = CW'(y_q) + CW'({h_q, 1'b0});
      f_col = nj[0] ? CW'(x_q) + CW'(w_q) : CW'(x_q);
   end

   logic [DIM_W-1:0] adv_x, adv_y;
   logic [WW-1:0]    adv_w, adv_h, grow_w;
   logic [3:0]       adv_s;
   logic             exhausted;

   // Next window position: x first, then y, then scale (W grows by 1.5x).
   always_comb begin
      grow_w    = w_q + (w_q >> 1);
      adv_x     = x_q + DIM_W'(1);
      adv_y     = y_q;
      adv_s     = s_q;
      adv_w     = w_q;
      adv_h     = h_q;
      exhausted = 1'b0;
      if (CW'(x_q) + CW'(1) > CW'(d_q) - CW'(w_q)) begin
         adv_x = '0;
         adv_y = y_q + DIM_W'(1);
         if (CW'(y_q) + CW'(1) > CW'(d_q) - CW'({h_q, 1'b0})) begin
            adv_y     = '0;
            adv_s     = s_q + 4'd1;
            adv_w     = grow_w;
            adv_h     = grow_w / WW'(6);
            exhausted = (adv_s == MAX_S) || (CW'(adv_w) > CW'(d_q)) ||
                        (CW'({adv_h, 1'b0}) > CW'(d_q));
         end
      end
   end

   logic [PIX_W-1:0] top, bot;
   logic [EW-1:0]    area, dark_lim, bright_lim;
   logic             hit, step;

   // rd[0..5] = I(y,x), I(y,x+W), I(y+H,x), I(y+H,x+W), I(y+2H,x), I(y+2H,x+W)
   always_comb begin
      top        = rd[3] - rd[2] - rd[1] + rd[0];
      bot        = rd[5] - rd[4] - rd[3] + rd[2];
      area       = EW'(w_q) * EW'(h_q);
      dark_lim   = EW'(td_q) * area;
      bright_lim = EW'(tb_q) * area;
      hit        = (EW'(top) < dark_lim) && (EW'(bot) > bright_lim);
      step       = ((state == EVAL) && !hit) || ((state == EMIT) && hit_ready);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         d_q       <= '0;
         w0_q      <= '0;
         td_q      <= '0;
         tb_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         w_q       <= '0;
         h_q       <= '0;
         s_q       <= '0;
         fc        <= '0;
         for (int i = 0; i < 6; i++) rd[i] <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         hit_valid <= 1'b0;
         hit_x     <= '0;
         hit_y     <= '0;
         hit_scale <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit_count <= '0;
         cfg_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               d_q   <= tile_dim;
               w0_q  <= base_w;
               td_q  <= t_dark;
               tb_q  <= t_bright;
               busy  <= 1'b1;
               state <= SETUP;
            end
            SETUP: begin
               s_q       <= '0;
               w_q       <= WW'(w0_q);
               h_q       <= setup_h;
               x_q       <= '0;
               y_q       <= '0;
               hit_count <= '0;
               cfg_err   <= (setup_h == '0);
               if (setup_h == '0 || w0_q > d_q) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= FETCH;
                  fc        <= '0;
                  mem_rd_en <= 1'b1;
                  mem_addr  <= '0;
               end
            end
            FETCH: begin
               // data for the read issued in cycle fc-1 is on the bus now
               if (fc != 3'd0) rd[fc - 3'd1] <= mem_rd_data;
               if (fc == 3'd6) begin
                  state <= EVAL;
               end else begin
                  fc        <= fc + 3'd1;
                  mem_rd_en <= (fc != 3'd5);
                  if (fc != 3'd5) mem_addr <= addr_of(f_row, f_col, pitch);
               end
            end
            EVAL: if (hit) begin
               state     <= EMIT;
               hit_valid <= 1'b1;
               hit_x     <= x_q;
               hit_y     <= y_q;
               hit_scale <= s_q[2:0];
            end
            EMIT: if (hit_ready) begin
               hit_valid <= 1'b0;
               if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // leaving EVAL (miss) or EMIT (transfer): move to the next window
         if (step) begin
            x_q <= adv_x;
            y_q <= adv_y;
            s_q <= adv_s;
            w_q <= adv_w;
            h_q <= adv_h;
            if (exhausted) begin
               state <= DONE;
               done  <= 1'b1;
            end else begin
               state     <= FETCH;
               fc        <= '0;
               mem_rd_en <= 1'b1;
               mem_addr  <= addr_of(CW'(adv_y), CW'(adv_x), pitch);
            end
         end
      end
   end
endmodule
